// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_top transmitter among NUM_REQ byte requesters.
// Latches the granted byte, drives send/dintx, waits for donetx (or a watchdog) and enforces an idle gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int CLK_FREQ    = 1000000,
    parameter int BAUD        = 9600,
    parameter int SEND_HOLD   = CLK_FREQ / BAUD,
    parameter int GAP_CYC     = CLK_FREQ / BAUD,
    parameter int TIMEOUT_CYC = 16 * CLK_FREQ / BAUD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [8*NUM_REQ-1:0]         req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         err,
    output logic [$clog2(NUM_REQ)-1:0]   gnt_id,
    output logic                         busy,
    output logic [7:0]                   dintx,
    output logic                         send,
    input  logic                         donetx
);

    localparam int IDW       = $clog2(NUM_REQ);
    localparam int MAX_A     = (SEND_HOLD > GAP_CYC) ? SEND_HOLD : GAP_CYC;
    localparam int MAX_CNT   = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int CW        = $clog2(MAX_CNT + 1);
    localparam int SEND_LAST = (SEND_HOLD > 0) ? SEND_HOLD - 1 : 0;
    localparam int GAP_LAST  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam int TO_LAST   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        GAP
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    phase_cnt;
    logic [CW-1:0]    to_cnt;
    logic [CW-1:0]    to_next;
    logic             donetx_q;
    logic             done_rise;
    logic             done_pend;
    logic             timeout_hit;
    logic [IDW-1:0]   pick;
    logic             pick_valid;
    logic [7:0]       pick_data;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDW'(sum);
    endfunction

    assign done_rise   = donetx & ~donetx_q;
    assign timeout_hit = (to_cnt >= CW'(TO_LAST));
    assign to_next     = (to_cnt == CW'(MAX_CNT)) ? to_cnt : to_cnt + CW'(1);

    // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[wrap_idx(rr_ptr, i)]) begin
                pick       = wrap_idx(rr_ptr, i);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        pick_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDW'(i)) pick_data = req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) donetx_q <= 1'b0;
        else      donetx_q <= donetx;
    end

    // ack/err default low every cycle so any assignment below is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ack       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            send      <= 1'b0;
            dintx     <= 8'h00;
            gnt_id    <= '0;
            rr_ptr    <= IDW'(NUM_REQ - 1);
            phase_cnt <= '0;
            to_cnt    <= '0;
            done_pend <= 1'b0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        dintx     <= pick_data;
                        gnt_id    <= pick;
                        rr_ptr    <= pick;
                        send      <= 1'b1;
                        busy      <= 1'b1;
                        phase_cnt <= '0;
                        to_cnt    <= '0;
                        done_pend <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    to_cnt <= to_next;
                    if (done_rise) done_pend <= 1'b1;
                    if (timeout_hit) begin
                        ack[gnt_id] <= 1'b1;
                        err         <= ~(done_rise | done_pend);
                        send        <= 1'b0;
                        phase_cnt   <= '0;
                        state       <= GAP;
                    end else if (phase_cnt == CW'(SEND_LAST)) begin
                        send      <= 1'b0;
                        phase_cnt <= '0;
                        state     <= WAIT_DONE;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    to_cnt <= to_next;
                    // A completion edge beats a watchdog expiry landing on the same cycle.
                    if (done_rise || done_pend) begin
                        ack[gnt_id] <= 1'b1;
                        phase_cnt   <= '0;
                        state       <= GAP;
                    end else if (timeout_hit) begin
                        ack[gnt_id] <= 1'b1;
                        err         <= 1'b1;
                        send        <= 1'b0;
                        phase_cnt   <= '0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    to_cnt    <= '0;
                    done_pend <= 1'b0;
                    if (phase_cnt >= CW'(GAP_LAST)) begin
                        phase_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    send  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst) $onehot0(ack));
    assert property (@(posedge clk) disable iff (!rst) err |-> (|ack));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, corner-case sequences and a
// randomized run, all compared every cycle against a frame-level timing and round-robin model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int H  = 4;
    localparam int G  = 5;
    localparam int T  = 40;
    localparam int DW = 8 * N;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           req;
    logic [DW-1:0]          req_data;
    logic [N-1:0]           ack;
    logic                   err;
    logic [$clog2(N)-1:0]   gnt_id;
    logic                   busy;
    logic [7:0]             dintx;
    logic                   send;
    logic                   donetx;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit         m_frame;
    int         m_s, m_d, m_a, m_next_ok, m_k, m_last, m_gnt;
    logic [7:0] m_byte;
    bit         dn_prev;

    bit           obs_active, send_prev, rise_flag, ack_flag;
    int           obs_s, obs_a, obs_gnt;
    logic [7:0]   obs_byte;
    logic [N-1:0] obs_ack;
    logic         obs_err;
    int           done_delay;
    bit           rand_mode;

    typedef struct {
        logic [N-1:0]  req;
        logic [DW-1:0] data;
        int            dly;
        int            exp_gnt;
        logic [7:0]    exp_byte;
        logic          exp_err;
    } vec_t;

    vec_t tab [8];

    uart_tx_arbiter #(
        .NUM_REQ(N), .CLK_FREQ(1000000), .BAUD(250000),
        .SEND_HOLD(H), .GAP_CYC(G), .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .err(err),
        .gnt_id(gnt_id), .busy(busy), .dintx(dintx), .send(send), .donetx(donetx)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock: capture the inputs the edge will see, advance, then compare against the model.
    task automatic step();
        logic [N-1:0]  r_at;
        logic [DW-1:0] d_at;
        logic          dn_at;
        logic [N-1:0]  exp_ack;
        logic          exp_err, exp_send, exp_busy;
        bit            chk_data;
        r_at = req;
        d_at = req_data;
        dn_at = donetx;
        @(posedge clk);
        #1;
        cyc++;
        exp_ack  = '0;
        exp_err  = 1'b0;
        chk_data = 0;
        if (m_frame) begin
            chk_data = 1;
            if (dn_at && !dn_prev && m_d < 0) m_d = cyc;
            if (m_d >= 0 && cyc == max2(m_d, m_s + H + 1)) begin
                exp_ack[m_k] = 1'b1;
            end else if (m_d < 0 && cyc == m_s + T) begin
                exp_ack[m_k] = 1'b1;
                exp_err = 1'b1;
            end
            if (exp_ack != '0) begin
                m_frame = 0;
                m_a = cyc;
                m_next_ok = cyc + G + 1;
            end
        end else if (cyc >= m_next_ok && r_at != '0) begin
            m_k = rr_pick(r_at, m_last);
            m_last = m_k;
            m_gnt = m_k;
            m_byte = d_at[8*m_k +: 8];
            m_s = cyc;
            m_d = -1;
            m_frame = 1;
            chk_data = 1;
        end
        dn_prev = dn_at;
        exp_send = m_frame && (cyc < m_s + H);
        exp_busy = m_frame || (cyc < m_a + G);
        check_output("send", send, exp_send);
        check_output("busy", busy, exp_busy);
        check_output("ack", ack, exp_ack);
        check_output("err", err, exp_err);
        check_output("gnt_id", gnt_id, m_gnt);
        if (chk_data) check_output("dintx", dintx, m_byte);

        if (send && !send_prev) begin
            obs_active = 1;
            obs_s = cyc;
            obs_gnt = gnt_id;
            obs_byte = dintx;
            rise_flag = 1;
            if (rand_mode) begin
                case ($urandom_range(0, 9))
                    0:       done_delay = -1;
                    1:       done_delay = T - 2 + int'($urandom_range(0, 2));
                    default: done_delay = int'($urandom_range(0, 12));
                endcase
            end
        end
        send_prev = send;
        if (ack != '0) begin
            obs_active = 0;
            obs_a = cyc;
            obs_ack = ack;
            obs_err = err;
            ack_flag = 1;
        end
        donetx = obs_active && done_delay >= 0 && (cyc - obs_s) >= done_delay
                 && (cyc - obs_s) <= done_delay + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_ack(input int budget);
        ack_flag = 0;
        for (int i = 0; i < budget && !ack_flag; i++) step();
        checks++;
        if (!ack_flag) begin
            errors++;
            $display("[TB] FAIL ack_wait actual=no ack in %0d cycles required=ack pulse", budget);
        end
    endtask

    task automatic wait_rise(input int budget);
        rise_flag = 0;
        for (int i = 0; i < budget && !rise_flag; i++) step();
        checks++;
        if (!rise_flag) begin
            errors++;
            $display("[TB] FAIL send_wait actual=no send rise in %0d cycles required=rise", budget);
        end
    endtask

    // Reset is checked asynchronously, then the model returns to its power-on view.
    task automatic apply_reset(input int hold);
        rst = 1'b0;
        donetx = 1'b0;
        #1;
        check_output("rst_busy", busy, 0);
        check_output("rst_send", send, 0);
        check_output("rst_ack", ack, 0);
        check_output("rst_err", err, 0);
        repeat (hold) @(posedge clk);
        #1;
        check_output("rst_gnt", gnt_id, 0);
        check_output("rst_dintx", dintx, 0);
        m_frame = 0; m_last = N - 1; m_gnt = 0; m_byte = 8'h00;
        m_a = -1000; m_next_ok = cyc + 1; m_d = -1;
        dn_prev = 0; send_prev = 0; obs_active = 0;
        rst = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] r, input logic [DW-1:0] d, input int dly);
        req = r;
        req_data = d;
        done_delay = dly;
    endtask

    logic [7:0]   exp_a [5];
    logic [N-1:0] onehot;
    int           prev_a;

    initial begin
        tab[0] = '{4'b0100, 32'h00A5_0000,  3,     2, 8'hA5, 1'b0};
        tab[1] = '{4'b1010, 32'h3C00_5A00,  5,     3, 8'h3C, 1'b0};
        tab[2] = '{4'b1010, 32'h3C00_5A00,  0,     1, 8'h5A, 1'b0};
        tab[3] = '{4'b1010, 32'h3C00_5A00,  T - 1, 3, 8'h3C, 1'b0};
        tab[4] = '{4'b0001, 32'h0000_00E7, -1,     0, 8'hE7, 1'b1};
        tab[5] = '{4'b0011, 32'h0000_9C81,  2,     1, 8'h9C, 1'b0};
        tab[6] = '{4'b0011, 32'h0000_9C81,  T,     0, 8'h81, 1'b1};
        tab[7] = '{4'b1000, 32'hF000_0000,  8,     3, 8'hF0, 1'b0};
        exp_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        rst = 1'b1; req = '0; req_data = '0; donetx = 1'b0; done_delay = 3; rand_mode = 0;
        #2;
        apply_reset(3);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(tab[i].req, tab[i].data, tab[i].dly);
            wait_ack(T + 20);
            req = '0;
            onehot = '0;
            onehot[tab[i].exp_gnt] = 1'b1;
            check_output("tab_gnt", obs_gnt, tab[i].exp_gnt);
            check_output("tab_byte", obs_byte, tab[i].exp_byte);
            check_output("tab_ack", obs_ack, onehot);
            check_output("tab_err", obs_err, tab[i].exp_err);
            idle(G + 3);
        end

        apply_stimulus(4'b1111, 32'h4433_2211, 5);
        prev_a = 0;
        for (int j = 0; j < 5; j++) begin
            wait_ack(T + 20);
            check_output("rr_byte", obs_byte, exp_a[j]);
            if (j > 0) check_output("gap_len", obs_s - prev_a, G + 1);
            prev_a = obs_a;
        end
        req = '0;
        idle(G + 3);

        apply_stimulus(4'b0001, 32'h0000_00C3, 6);
        wait_rise(20);
        idle(2);
        req = '0;
        req_data = 32'h0000_00FF;
        wait_ack(T + 20);
        check_output("drop_byte", obs_byte, 8'hC3);
        check_output("drop_ack", obs_ack, 4'b0001);
        idle(G + 3);

        apply_stimulus(4'b0110, 32'h0077_6600, -1);
        wait_ack(T + 20);
        req = 4'b0100;
        done_delay = 4;
        check_output("to_ack", obs_ack, 4'b0010);
        check_output("to_err", obs_err, 1);
        check_output("to_time", obs_a - obs_s, T);
        wait_ack(T + 20);
        req = '0;
        check_output("to_next_gnt", obs_gnt, 2);
        check_output("to_next_byte", obs_byte, 8'h77);
        check_output("to_next_err", obs_err, 0);
        idle(G + 3);

        apply_stimulus(4'b0100, 32'h00D4_0000, -1);
        wait_rise(20);
        idle(H + 3);
        apply_reset(2);
        apply_stimulus(4'b1111, 32'h4433_2211, 3);
        wait_ack(T + 20);
        req = '0;
        check_output("post_rst_gnt", obs_gnt, 0);
        check_output("post_rst_byte", obs_byte, 8'h11);
        check_output("post_rst_ack", obs_ack, 4'b0001);
        idle(G + 3);

        rand_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_data = DW'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single transmitter of uart_top among NUM_REQ byte requesters. It captures one requester's byte and drives dintx/send toward uart_top. It then waits for donetx, acknowledges the requester, and enforces an idle gap before the next frame. A watchdog flags a transmitter that never reports completion, so requesters are never deadlocked.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLK_FREQ, 1000000, system clock frequency in Hz (matches uart_top)
BAUD, 9600, line baud rate (matches uart_top)
SEND_HOLD, CLK_FREQ/BAUD, cycles send is held high (>= one uart_top baud tick)
GAP_CYC, CLK_FREQ/BAUD, idle cycles between frames
TIMEOUT_CYC, 16*CLK_FREQ/BAUD, max cycles from send rise to donetx rise

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request level
req_data  in  8*NUM_REQ  requester i byte in bits [8i+7:8i]
ack  out  NUM_REQ  one-cycle pulse: requester's byte finished (or timed out)
err  out  1  one-cycle pulse coincident with ack on timeout
gnt_id  out  $clog2(NUM_REQ)  index of the requester currently or last served
busy  out  1  high in every state except IDLE
dintx  out  8  byte to uart_top dintx
send  out  1  to uart_top send
donetx  in  1  from uart_top donetx

Behaviour:
- Reset (rst=0, async): state IDLE. ack=0, err=0, busy=0, send=0, dintx=8'h00, gnt_id=0. rr_ptr=NUM_REQ-1, so requester 0 has first priority. donetx_q=0. All counters 0.
- donetx_q registers donetx each cycle. done_rise = donetx & ~donetx_q.
- IDLE: if any req bit is set, search from rr_ptr+1 upward with modulo-NUM_REQ wrap. Select the first set bit k.
  - Next cycle: dintx<=req_data[k], gnt_id<=k, rr_ptr<=k, send<=1, counters cleared, state SEND.
  - If req is all zero, stay in IDLE.
- SEND: send held high for exactly SEND_HOLD cycles, then send<=0 and state WAIT_DONE.
  - dintx stays stable from SEND entry until GAP entry.
- WAIT_DONE:
  - On done_rise: ack[gnt_id] pulses for 1 cycle, then state GAP.
  - A done_rise seen during SEND also counts: it is recorded and honoured on WAIT_DONE entry.
- Timeout: the counter runs from SEND entry. When it reaches TIMEOUT_CYC with no done_rise:
  - ack[gnt_id] and err pulse together for 1 cycle; send<=0; state GAP.
  - If timeout and done_rise occur in the same cycle, done_rise wins and err stays 0.
- GAP: count GAP_CYC cycles with send=0, then return to IDLE. Arbitration happens in IDLE only, so new frames start at least GAP_CYC+1 cycles after ack.
- Request handshake:
  - The requester holds req[i] and its data until ack[i].
  - The byte is latched at grant. If req drops or data changes after grant, the latched byte is still sent and ack is still pulsed.
  - A req still high on the cycle after ack is treated as a new request.
- Fairness: with all requesters active, the grant order is 0,1,2,3,0,... No requester waits more than NUM_REQ-1 frames.
- At most one ack bit is high in any cycle. ack is never high outside the cycle leaving WAIT_DONE (or the timeout cycle).
- Mid-operation reset: all outputs return to reset values immediately. The in-flight frame is abandoned with no ack. rr_ptr returns to NUM_REQ-1.
- Counter widths: wide enough for max(SEND_HOLD, GAP_CYC, TIMEOUT_CYC) with no wrap. Every counter saturates or is cleared on state exit.

Test Plan:
- Single request: req=4'b0100, byte 8'hA5 -> gnt_id=2, dintx=8'hA5. send is high for SEND_HOLD cycles, a frame appears on tx, and ack[2] pulses once, 1 cycle after the donetx rise.
- All four requests held high with bytes 11,22,33,44 -> bytes leave in order 11,22,33,44,11. Each ack is followed by at least GAP_CYC idle cycles before the next send rise.
- Grant wrap: after serving requester 3, requests on 1 and 3 -> requester 1 is served next, then 3.
- Req dropped after grant: req[0] is released 2 cycles after grant -> byte is still transmitted and ack[0] still pulses.
- Timeout: force donetx=0 -> ack[gnt_id] and err pulse together exactly TIMEOUT_CYC cycles after the send rise, then GAP, and the next requester is served.
- Reset during WAIT_DONE: assert rst=0 -> busy, send and ack drop asynchronously with no ack pulse. After release, req=4'b1111 grants requester 0 first.
